aes32_pcpi_sequencer: RTL and testbench
=======================================

// Module: aes32_pcpi_sequencer
// PURPOSE
//  Sequences one RISC-V Zkne/Zknd AES32 instruction per request over the PicoRV32 PCPI port.
//  Decodes the instruction and selects byte rs2[8*bs+:8]. Sends it through a shared
//  registered S-box unit, applies the (Inv)MixColumn step, rotates by 8*bs, XORs with rs1.
//  Returns rd to the core with a pcpi_wait/pcpi_ready/pcpi_wr handshake.
//  Sits beside picorv32 in the picosoc AES coprocessor path.
// PARAMETERS
//  EXTRA_LAT  0   extra wait cycles inserted between S-box lookup and mix (0..7), timing closure
//  CNT_W      16  width of op_count
// PORTS
//  clk         in   1      system clock, rising edge
//  resetn      in   1      asynchronous active-low reset
//  pcpi_valid  in   1      core presents a custom/unknown instruction
//  pcpi_insn   in   32     instruction word
//  pcpi_rs1    in   32     rs1 operand (XOR base)
//  pcpi_rs2    in   32     rs2 operand (byte source)
//  pcpi_wr     out  1      rd write enable, pulses with pcpi_ready
//  pcpi_rd     out  32     result
//  pcpi_wait   out  1      instruction claimed, result pending
//  pcpi_ready  out  1      result valid, one-cycle pulse
//  busy        out  1      FSM not in IDLE
//  op_count    out  CNT_W  completed-instruction counter, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: pcpi_wr=0, pcpi_rd=0, pcpi_ready=0, op_count=0, FSM=IDLE.
//   pcpi_wait and busy are 0 in reset.
//  Decode (match): opcode 7'h33, funct3 3'b000.
//   funct7[4:0] = 10001 esi, 10011 esmi, 10101 dsi, 10111 dsmi; bs = funct7[6:5].
//  pcpi_wait is combinational = (IDLE & pcpi_valid & match) | LOOKUP | WAITX | MIX.
//  FSM:
//   IDLE   -> LOOKUP on pcpi_valid & match; latch rs1, byte, bs, op.
//   LOOKUP -> WAITX if EXTRA_LAT>0, else -> MIX. Registered S-box output is valid next cycle.
//   WAITX  -> counts EXTRA_LAT cycles, then -> MIX.
//   MIX    -> DONE. Registers the result into pcpi_rd.
//   DONE   -> HOLD. pcpi_ready=1 and pcpi_wr=1 for this cycle only; op_count+1.
//   HOLD   -> IDLE. pcpi_valid is ignored here, so the request just retired is not re-accepted.
//  Latency: ready asserts exactly 4+EXTRA_LAT cycles after the accepting edge.
//  Result: x = S(b) or S^-1(b) per op.
//   Mixed word for esmi, MSB..LSB: {3x, x, x, 2x}.
//   Mixed word for dsmi, MSB..LSB: {0b*x, 0d*x, 09*x, 0e*x}; GF(2^8) with poly 0x11B.
//   esi/dsi mixed word = {24'h0, x}.
//   rd = rs1 ^ rol32(mixed, 8*bs).
//  Abort: pcpi_valid low in LOOKUP, WAITX or MIX -> IDLE next cycle.
//   On abort: no ready, no wr, op_count unchanged.
//  Non-matching insn: never wait/ready, so the core's PCPI timeout/trap path handles it.
//  Async reset mid-operation: returns to IDLE at once; any partial result is discarded.
// CONFIGURATION
//  AES32_DEC_EN defined: dsi/dsmi decoded; inverse S-box table built; dsmi mixing present.
//  AES32_DEC_EN undefined: only esi/esmi match; dsi/dsmi are unclaimed (no wait/ready).
//   In that case, no inverse S-box table or dsmi mixing logic is synthesised.
// STRUCTURE
//  Package aes32_pkg: op enum (ESI, ESMI, DSI, DSMI), funct7 low-5 codes, OPCODE_OP,
//   GF xtime function, FSM state enum.
//  Sub-module aes_sbox_unit (clk, resetn, inv, din[7:0] -> dout[7:0]).
//   Output is registered with one-cycle latency.
//   Holds the forward table and, under AES32_DEC_EN, the inverse table.
// TESTING
//  esi  bs=0, rs1=0, rs2=0                -> pcpi_rd=32'h00000063, wr&ready, 4 cycles after accept.
//  esi  bs=2, rs1=0, rs2=0                -> pcpi_rd=32'h00630000.
//  esmi bs=0, rs1=0, rs2=0                -> pcpi_rd=32'hA56363C6. Repeat with bs=1 -> 32'h6363C6A5.
//  dsi  bs=1, rs1=32'h12345678, rs2=0     -> 32'h12340478.
//   dsmi bs=0, rs1=0, rs2=0 -> 32'h50A7F451.
//   Both are unclaimed (wait stays 0) when AES32_DEC_EN is undefined.
//  Drop pcpi_valid in MIX -> no ready, op_count unchanged; the next esi completes normally.
//   Also assert resetn low mid-LOOKUP -> all outputs return to reset values.
//  Back-to-back valid held through HOLD -> exactly one ready pulse per request.
//   Run with EXTRA_LAT=3 -> latency 7 cycles.
//   Preload op_count to all-ones (force) -> wraps to 0.

Source files
------------

// File: rtl/aes32_pkg.sv
// rtl/aes32_pkg.sv - shared types, decode constants and GF(2^8) helpers for the AES32 PCPI sequencer
package aes32_pkg;

    typedef enum logic [1:0] {
        OP_ESI,
        OP_ESMI,
        OP_DSI,
        OP_DSMI
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAITX,
        ST_MIX,
        ST_DONE,
        ST_HOLD
    } state_e;

    localparam logic [6:0] OPCODE_OP = 7'h33;
    localparam logic [4:0] F5_ESI    = 5'b10001;
    localparam logic [4:0] F5_ESMI   = 5'b10011;
    localparam logic [4:0] F5_DSI    = 5'b10101;
    localparam logic [4:0] F5_DSMI   = 5'b10111;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox_unit.sv
// rtl/aes_sbox_unit.sv - registered AES S-box (forward; inverse too when AES32_DEC_EN is defined)
module aes_sbox_unit
    import aes32_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       inv,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Field inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] fwd_inv;
    logic [7:0] dout_d;
    logic [7:0] dout_q;

    always_comb begin
        fwd_inv = gf_inv(din);
        dout_d  = fwd_inv ^ rotl8(fwd_inv, 1) ^ rotl8(fwd_inv, 2) ^ rotl8(fwd_inv, 3)
                ^ rotl8(fwd_inv, 4) ^ 8'h63;
`ifdef AES32_DEC_EN
        if (inv) dout_d = gf_inv(rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05);
`endif
    end

`ifndef AES32_DEC_EN
    logic unused_inv;
    assign unused_inv = inv;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) dout_q <= 8'h00;
        else         dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/aes32_pcpi_sequencer.sv
// rtl/aes32_pcpi_sequencer.sv - AES32 (Zkne/Zknd) PCPI sequencer; decrypt ops gated by AES32_DEC_EN
module aes32_pcpi_sequencer
    import aes32_pkg::*;
#(
    parameter int EXTRA_LAT = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pcpi_valid,
    input  logic [31:0]      pcpi_insn,
    input  logic [31:0]      pcpi_rs1,
    input  logic [31:0]      pcpi_rs2,
    output logic             pcpi_wr,
    output logic [31:0]      pcpi_rd,
    output logic             pcpi_wait,
    output logic             pcpi_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e            state_q, state_d;
    op_e               op_q, op_d, dec_op;
    logic              dec_match;
    logic [31:0]       rs1_q, rs1_d;
    logic [7:0]        byte_q, byte_d, dec_byte;
    logic [1:0]        bs_q, bs_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        sbox_x;
    logic [31:0]       mixed, rotated;

    logic unused_insn;
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

    always_comb begin
        dec_match = 1'b0;
        dec_op    = OP_ESI;
        if (pcpi_insn[6:0] == OPCODE_OP && pcpi_insn[14:12] == 3'b000) begin
            case (pcpi_insn[29:25])
                F5_ESI:  begin dec_match = 1'b1; dec_op = OP_ESI;  end
                F5_ESMI: begin dec_match = 1'b1; dec_op = OP_ESMI; end
`ifdef AES32_DEC_EN
                F5_DSI:  begin dec_match = 1'b1; dec_op = OP_DSI;  end
                F5_DSMI: begin dec_match = 1'b1; dec_op = OP_DSMI; end
`endif
                default: ;
            endcase
        end
        case (pcpi_insn[31:30])
            2'd0:    dec_byte = pcpi_rs2[7:0];
            2'd1:    dec_byte = pcpi_rs2[15:8];
            2'd2:    dec_byte = pcpi_rs2[23:16];
            default: dec_byte = pcpi_rs2[31:24];
        endcase
    end

    aes_sbox_unit u_sbox (
        .clk    (clk),
        .resetn (resetn),
        .inv    (op_q == OP_DSI || op_q == OP_DSMI),
        .din    (byte_q),
        .dout   (sbox_x)
    );

    always_comb begin
        case (op_q)
            OP_ESMI: mixed = {xtime(sbox_x) ^ sbox_x, sbox_x, sbox_x, xtime(sbox_x)};
`ifdef AES32_DEC_EN
            OP_DSMI: mixed = {gf_mul(sbox_x, 8'h0b), gf_mul(sbox_x, 8'h0d),
                              gf_mul(sbox_x, 8'h09), gf_mul(sbox_x, 8'h0e)};
`endif
            default: mixed = {24'h0, sbox_x};
        endcase
        case (bs_q)
            2'd0:    rotated = mixed;
            2'd1:    rotated = {mixed[23:0], mixed[31:24]};
            2'd2:    rotated = {mixed[15:0], mixed[31:16]};
            default: rotated = {mixed[7:0],  mixed[31:8]};
        endcase
    end

    // Dropping pcpi_valid before DONE abandons the op; DONE/HOLD ignore valid so a retired request is not re-taken.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs1_d   = rs1_q;
        byte_d  = byte_q;
        bs_d    = bs_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (pcpi_valid && dec_match) begin
                    state_d = ST_LOOKUP;
                    op_d    = dec_op;
                    rs1_d   = pcpi_rs1;
                    byte_d  = dec_byte;
                    bs_d    = pcpi_insn[31:30];
                end
            end
            ST_LOOKUP: begin
                if (!pcpi_valid)        state_d = ST_IDLE;
                else if (EXTRA_LAT > 0) begin state_d = ST_WAITX; cnt_d = 3'd0; end
                else                    state_d = ST_MIX;
            end
            ST_WAITX: begin
                if (!pcpi_valid)                      state_d = ST_IDLE;
                else if (cnt_q == 3'(EXTRA_LAT - 1))  state_d = ST_MIX;
                else                                  cnt_d   = cnt_q + 3'd1;
            end
            ST_MIX: begin
                if (!pcpi_valid) state_d = ST_IDLE;
                else begin
                    rd_d    = rs1_q ^ rotated;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ESI;
            rs1_q   <= 32'h0;
            byte_q  <= 8'h00;
            bs_q    <= 2'd0;
            cnt_q   <= 3'd0;
            rd_q    <= 32'h0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            byte_q  <= byte_d;
            bs_q    <= bs_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign pcpi_wait  = resetn && ((state_q == ST_IDLE && pcpi_valid && dec_match)
                        || state_q == ST_LOOKUP || state_q == ST_WAITX || state_q == ST_MIX);
    assign pcpi_ready = (state_q == ST_DONE);
    assign pcpi_wr    = (state_q == ST_DONE);
    assign pcpi_rd    = rd_q;
    assign busy       = (state_q != ST_IDLE);
    assign op_count   = count_q;

endmodule

// File: tb/tb_aes32_pcpi_sequencer.sv
// tb/tb_aes32_pcpi_sequencer.sv - directed self-checking bench for aes32_pcpi_sequencer
module tb_aes32_pcpi_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [31:0] insn = 32'h0, rs1 = 32'h0, rs2 = 32'h0;

    logic        wr0, wait0, rdy0, busy0, wr1, wait1, rdy1, busy1;
    logic [31:0] rd0, rd1;
    logic [15:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses0  = 0;
    logic [15:0] exp_cnt = 16'h0;

    always #5 clk = ~clk;

    always @(negedge clk) if (rdy0) pulses0 <= pulses0 + 1;

    aes32_pcpi_sequencer #(.EXTRA_LAT(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .resetn(resetn), .pcpi_valid(v0), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr0), .pcpi_rd(rd0),
        .pcpi_wait(wait0), .pcpi_ready(rdy0), .busy(busy0), .op_count(cnt0));

    aes32_pcpi_sequencer #(.EXTRA_LAT(3), .CNT_W(16)) u_dut1 (
        .clk(clk), .resetn(resetn), .pcpi_valid(v1), .pcpi_insn(insn),
        .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr1), .pcpi_rd(rd1),
        .pcpi_wait(wait1), .pcpi_ready(rdy1), .busy(busy1), .op_count(cnt1));

    function automatic logic [31:0] mk(input logic [1:0] bs, input logic [4:0] f5);
        return {bs, f5, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33};
    endfunction

    // Latency is numbered with the accepting cycle as 1.
    task automatic run_op(input bit sel, input bit hold, input logic [31:0] i,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rd, output int lat, output logic wr_seen);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((sel ? busy1 : busy0) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        insn = i; rs1 = a; rs2 = b;
        if (sel) v1 = 1'b1; else v0 = 1'b1;
        lat = 1; rd = 32'hx; wr_seen = 1'b0;
        while (lat <= 40) begin
            @(negedge clk);
            lat++;
            if (sel ? rdy1 : rdy0) begin
                rd = sel ? rd1 : rd0;
                wr_seen = sel ? wr1 : wr0;
                break;
            end
        end
        if (!hold) begin v0 = 1'b0; v1 = 1'b0; end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if ({wait0, rdy0, wr0, busy0, wait1, rdy1, wr1, busy1} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 00000000",
                {wait0, rdy0, wr0, busy0, wait1, rdy1, wr1, busy1});
        end
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h exp 00000000", rd0); end
        n_checks++;
        if (cnt0 !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0000", cnt0); end
        resetn = 1'b1;
    endtask

    task automatic test_esi;
        logic [31:0] r; int l; logic w;
        logic [1:0]  bs   [3] = '{2'd0, 2'd2, 2'd3};
        logic [31:0] src  [3] = '{32'h0, 32'h0, 32'h53000000};
        logic [31:0] expv [3] = '{32'h00000063, 32'h00630000, 32'hED000000};
        for (int k = 0; k < 3; k++) begin
            run_op(1'b0, 1'b0, mk(bs[k], 5'b10001), 32'h0, src[k], r, l, w);
            exp_cnt++;
            n_checks++;
            if (r !== expv[k]) begin n_fail++; $display("FAIL esi_rd[%0d] got %h exp %h", k, r, expv[k]); end
            n_checks++;
            if (l !== 4 || w !== 1'b1) begin n_fail++; $display("FAIL esi_lat_wr[%0d] got lat %0d wr %b exp 4 1", k, l, w); end
        end
    endtask

    task automatic test_esmi;
        logic [31:0] r; int l; logic w;
        run_op(1'b0, 1'b0, mk(2'd0, 5'b10011), 32'h0, 32'h0, r, l, w);
        exp_cnt++;
        n_checks++;
        if (r !== 32'hA56363C6) begin n_fail++; $display("FAIL esmi_bs0 got %h exp A56363C6", r); end
        run_op(1'b0, 1'b0, mk(2'd1, 5'b10011), 32'h0, 32'h0, r, l, w);
        exp_cnt++;
        n_checks++;
        if (r !== 32'h6363C6A5) begin n_fail++; $display("FAIL esmi_bs1 got %h exp 6363C6A5", r); end
        @(negedge clk);
        n_checks++;
        if (cnt0 !== exp_cnt) begin n_fail++; $display("FAIL esmi_count got %h exp %h", cnt0, exp_cnt); end
    endtask

    task automatic test_dec;
`ifdef AES32_DEC_EN
        logic [31:0] r; int l; logic w;
        run_op(1'b0, 1'b0, mk(2'd1, 5'b10101), 32'h12345678, 32'h0, r, l, w);
        exp_cnt++;
        n_checks++;
        if (r !== 32'h12340478) begin n_fail++; $display("FAIL dsi_bs1 got %h exp 12340478", r); end
        run_op(1'b0, 1'b0, mk(2'd0, 5'b10111), 32'h0, 32'h0, r, l, w);
        exp_cnt++;
        n_checks++;
        if (r !== 32'h50A7F451) begin n_fail++; $display("FAIL dsmi_bs0 got %h exp 50A7F451", r); end
`else
        logic seen;
        logic [4:0] f5 [2] = '{5'b10101, 5'b10111};
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            @(negedge clk);
            insn = mk(2'd0, f5[k]); rs1 = 32'h0; rs2 = 32'h0; v0 = 1'b1;
            repeat (8) begin
                #1 seen = seen | wait0 | rdy0 | busy0;
                @(negedge clk);
            end
            v0 = 1'b0;
            n_checks++;
            if (seen !== 1'b0) begin n_fail++; $display("FAIL dec_unclaimed[%0d] got %b exp 0", k, seen); end
        end
`endif
    endtask

    task automatic test_nonmatch;
        logic seen;
        logic [31:0] bad [2];
        bad[0] = mk(2'd0, 5'b10001) | 32'h00001000;
        bad[1] = {mk(2'd0, 5'b10001)} ^ 32'h00000038;
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            @(negedge clk);
            insn = bad[k]; v0 = 1'b1;
            repeat (6) begin
                #1 seen = seen | wait0 | rdy0 | busy0;
                @(negedge clk);
            end
            v0 = 1'b0;
            n_checks++;
            if (seen !== 1'b0) begin n_fail++; $display("FAIL nonmatch[%0d] got %b exp 0", k, seen); end
        end
    endtask

    task automatic test_abort;
        logic [31:0] r; int l; logic w; logic seen;
        seen = 1'b0;
        @(negedge clk);
        insn = mk(2'd0, 5'b10001); rs1 = 32'h0; rs2 = 32'h0; v0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        v0 = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | rdy0 | wr0;
        end
        n_checks++;
        if (seen !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL abort_ready got %b busy %b exp 0 0", seen, busy0); end
        n_checks++;
        if (cnt0 !== exp_cnt) begin n_fail++; $display("FAIL abort_count got %h exp %h", cnt0, exp_cnt); end
        run_op(1'b0, 1'b0, mk(2'd0, 5'b10001), 32'hA5A5A5A5, 32'h0, r, l, w);
        exp_cnt++;
        n_checks++;
        if (r !== 32'hA5A5A5C6 || l !== 4) begin n_fail++; $display("FAIL abort_next got %h lat %0d exp A5A5A5C6 4", r, l); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        insn = mk(2'd0, 5'b10001); v0 = 1'b1;
        @(negedge clk);
        #2 resetn = 1'b0; v0 = 1'b0;
        #1;
        n_checks++;
        if ({wait0, rdy0, wr0, busy0} !== 4'h0 || rd0 !== 32'h0 || cnt0 !== 16'h0) begin
            n_fail++; $display("FAIL reset_mid got ctl %b rd %h cnt %h exp 0000 00000000 0000",
                {wait0, rdy0, wr0, busy0}, rd0, cnt0);
        end
        exp_cnt = 16'h0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] r; int l; logic w; int p0;
        p0 = pulses0;
        run_op(1'b0, 1'b1, mk(2'd1, 5'b10001), 32'h0, 32'h0, r, l, w);
        exp_cnt++;
        n_checks++;
        if (r !== 32'h00006300) begin n_fail++; $display("FAIL b2b_first got %h exp 00006300", r); end
        @(negedge clk);
        n_checks++;
        if (rdy0 !== 1'b0 || wait0 !== 1'b0) begin n_fail++; $display("FAIL b2b_hold got rdy %b wait %b exp 0 0", rdy0, wait0); end
        run_op(1'b0, 1'b1, mk(2'd0, 5'b10011), 32'hFFFFFFFF, 32'h0, r, l, w);
        exp_cnt++;
        n_checks++;
        if (r !== 32'h5A9C9C39) begin n_fail++; $display("FAIL b2b_second got %h exp 5A9C9C39", r); end
        @(negedge clk);
        v0 = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (pulses0 - p0 !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 2", pulses0 - p0); end
    endtask

    task automatic test_extra_lat;
        logic [31:0] r; int l; logic w;
        run_op(1'b1, 1'b0, mk(2'd0, 5'b10001), 32'h0, 32'h00000053, r, l, w);
        n_checks++;
        if (r !== 32'h000000ED || l !== 7 || w !== 1'b1) begin
            n_fail++; $display("FAIL extra_lat got rd %h lat %0d wr %b exp 000000ED 7 1", r, l, w);
        end
        @(negedge clk);
        n_checks++;
        if (cnt1 !== 16'h1) begin n_fail++; $display("FAIL extra_lat_count got %h exp 0001", cnt1); end
    endtask

    task automatic test_wrap;
        logic [31:0] r; int l; logic w;
        @(negedge clk);
        force u_dut0.count_q = 16'hFFFF;
        @(negedge clk);
        release u_dut0.count_q;
        run_op(1'b0, 1'b0, mk(2'd0, 5'b10001), 32'h0, 32'h0, r, l, w);
        @(negedge clk);
        n_checks++;
        if (cnt0 !== 16'h0000 || r !== 32'h00000063) begin
            n_fail++; $display("FAIL wrap got cnt %h rd %h exp 0000 00000063", cnt0, r);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_esi;
        test_esmi;
        test_dec;
        test_nonmatch;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        test_extra_lat;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
